// File: rtl/claim_loader_pkg.sv
// Shared definitions for the claim table writer: ASCII codes, FSM state codes
// and the packed claim record also used by the scanner's RAM read path.
package claim_loader_pkg;

    localparam logic [7:0] ASC_HASH  = 8'h23;
    localparam logic [7:0] ASC_AT    = 8'h40;
    localparam logic [7:0] ASC_COMMA = 8'h2c;
    localparam logic [7:0] ASC_COLON = 8'h3a;
    localparam logic [7:0] ASC_X     = 8'h78;
    localparam logic [7:0] ASC_NL    = 8'h0a;
    localparam logic [7:0] ASC_SP    = 8'h20;
    localparam logic [7:0] ASC_CR    = 8'h0d;
    localparam logic [7:0] ASC_TAB   = 8'h09;
    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_9     = 8'h39;

    // Extra accumulator bits above the field width; only the id uses them.
    localparam int ID_EXTRA_BITS = 6;
    localparam int CLAIM_FW      = 10;

    localparam logic [2:0] ST_START = 3'd0;
    localparam logic [2:0] ST_SEP   = 3'd1;
    localparam logic [2:0] ST_NUM   = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_ERR   = 3'd5;

    typedef struct packed {
        logic [CLAIM_FW-1:0] x;
        logic [CLAIM_FW-1:0] y;
        logic [CLAIM_FW-1:0] w;
        logic [CLAIM_FW-1:0] h;
    } claim_rec_t;

    // Byte that closes field f: id '@', x ',', y ':', w 'x', h '\n'.
    function automatic logic [7:0] field_term(input logic [2:0] f);
        case (f)
            3'd0:    return ASC_AT;
            3'd1:    return ASC_COMMA;
            3'd2:    return ASC_COLON;
            3'd3:    return ASC_X;
            default: return ASC_NL;
        endcase
    endfunction

    function automatic logic is_ws(input logic [7:0] b);
        return (b == ASC_SP) || (b == ASC_CR) || (b == ASC_TAB);
    endfunction

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASC_0) && (b <= ASC_9);
    endfunction

endpackage

// File: rtl/claim_loader_dec_accum.sv
// Decimal accumulator: load a first digit, append further digits (acc*10+d),
// saturating at W bits and flagging results above 2^LIMIT_W-1.
module dec_accum #(
    parameter int W       = 16,
    parameter int LIMIT_W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         append,
    input  logic [3:0]   digit,
    output logic [W-1:0] acc,
    output logic [W-1:0] app_val,
    output logic         ovf
);

    localparam logic [W+3:0] LIMIT = (W+4)'((64'd1 << LIMIT_W) - 64'd1);

    logic [W-1:0] acc_q;
    logic         sat_q;
    logic [W+3:0] prod;
    logic         prod_wide;

    // acc*10+9 < 16*2^W, so four extra bits never wrap.
    assign prod      = ({4'b0000, acc_q} * (W+4)'(10)) + (W+4)'(digit);
    assign prod_wide = (prod[W+3:W] != 4'b0000);
    assign app_val   = (sat_q || prod_wide) ? '1 : prod[W-1:0];
    assign ovf       = sat_q || (prod > LIMIT);
    assign acc       = acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else if (load) begin
            acc_q <= W'(digit);
            sat_q <= 1'b0;
        end else if (append) begin
            acc_q <= app_val;
            sat_q <= sat_q || prod_wide;
        end
    end

endmodule

// File: rtl/claim_loader.sv
// Parses "#id @ x,y: wxh\n" lines from a byte stream and writes each claim as
// a packed {x,y,w,h} record into the claim RAM at consecutive addresses.
module claim_loader
    import claim_loader_pkg::*;
#(
    parameter int ADDR_WIDTH  = 11,
    parameter int FIELD_WIDTH = 10,
    parameter int MAX_CLAIMS  = 1236
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic                     wr_en,
    output logic [ADDR_WIDTH-1:0]    wr_addr,
    output logic [4*FIELD_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0]    claim_count,
    output logic                     done,
    output logic                     error,
    output logic [2:0]               dbg_state
);

    localparam int ACC_W = FIELD_WIDTH + ID_EXTRA_BITS;
    localparam logic [ADDR_WIDTH-1:0] MAX_C = ADDR_WIDTH'(MAX_CLAIMS);

    logic [2:0]             state;
    logic [2:0]             f;
    logic                   ws_q;
    logic                   last_q;
    logic [FIELD_WIDTH-1:0] x_q, y_q, w_q, h_q;
    logic [ADDR_WIDTH-1:0]  cnt;

    logic             fire, dig, ws, acc_load, acc_append, ovf;
    logic [ACC_W-1:0] acc, app_val;
    logic             unused_acc_hi;

    // Handshake: a byte moves when in_valid && in_ready on a rising edge.
    // in_ready is a function of state (and rst) only, never of in_valid.
    assign in_ready = !rst && ((state == ST_START) || (state == ST_SEP) || (state == ST_NUM));
    assign fire     = in_valid && in_ready;
    assign dig      = is_digit(in_data);
    assign ws       = is_ws(in_data);

    assign acc_load   = fire && (state == ST_SEP) && dig;
    assign acc_append = fire && (state == ST_NUM) && dig;

    // ASCII '0'..'9' carry the digit value in their low nibble.
    dec_accum #(.W(ACC_W), .LIMIT_W(FIELD_WIDTH)) u_acc (
        .clk     (clk),
        .rst     (rst),
        .load    (acc_load),
        .append  (acc_append),
        .digit   (in_data[3:0]),
        .acc     (acc),
        .app_val (app_val),
        .ovf     (ovf)
    );

    assign unused_acc_hi = ^{acc[ACC_W-1:FIELD_WIDTH], app_val[ACC_W-1:FIELD_WIDTH]};

    assign wr_en       = (state == ST_WRITE) && (cnt != MAX_C);
    assign wr_addr     = cnt;
    assign wr_data     = {x_q, y_q, w_q, h_q};
    assign claim_count = cnt;
    assign done        = (state == ST_DONE);
    assign error       = (state == ST_ERR);
    assign dbg_state   = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_START;
            f      <= 3'd0;
            ws_q   <= 1'b0;
            last_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            w_q    <= '0;
            h_q    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                ST_START: if (fire) begin
                    if (in_data == ASC_HASH) begin
                        state <= in_last ? ST_ERR : ST_SEP;
                        f     <= 3'd0;
                    end else if ((in_data == ASC_NL) || ws) begin
                        if (in_last) state <= ST_DONE;
                    end else begin
                        state <= ST_ERR;
                    end
                end
                ST_SEP: if (fire) begin
                    if (dig && in_last && (f == 3'd4)) begin
                        // Stream ends on a one-digit h with no newline.
                        h_q    <= FIELD_WIDTH'(in_data[3:0]);
                        last_q <= 1'b1;
                        state  <= ST_WRITE;
                    end else if (dig && !in_last) begin
                        ws_q  <= 1'b0;
                        state <= ST_NUM;
                    end else if (!ws || in_last) begin
                        state <= ST_ERR;
                    end
                end
                ST_NUM: if (fire) begin
                    if (dig) begin
                        if (ws_q || ((f != 3'd0) && ovf)) begin
                            state <= ST_ERR;
                        end else if (in_last) begin
                            if (f == 3'd4) begin
                                h_q    <= app_val[FIELD_WIDTH-1:0];
                                last_q <= 1'b1;
                                state  <= ST_WRITE;
                            end else begin
                                state <= ST_ERR;
                            end
                        end
                    end else if (in_data == field_term(f)) begin
                        if (in_last && (f != 3'd4)) begin
                            state <= ST_ERR;
                        end else begin
                            case (f)
                                3'd1:    x_q <= acc[FIELD_WIDTH-1:0];
                                3'd2:    y_q <= acc[FIELD_WIDTH-1:0];
                                3'd3:    w_q <= acc[FIELD_WIDTH-1:0];
                                3'd4:    h_q <= acc[FIELD_WIDTH-1:0];
                                default: ;
                            endcase
                            if (f == 3'd4) begin
                                last_q <= in_last;
                                state  <= ST_WRITE;
                            end else begin
                                f     <= f + 3'd1;
                                state <= ST_SEP;
                            end
                        end
                    end else if (ws) begin
                        if (in_last) begin
                            if (f == 3'd4) begin
                                h_q    <= acc[FIELD_WIDTH-1:0];
                                last_q <= 1'b1;
                                state  <= ST_WRITE;
                            end else begin
                                state <= ST_ERR;
                            end
                        end else begin
                            ws_q <= 1'b1;
                        end
                    end else begin
                        state <= ST_ERR;
                    end
                end
                ST_WRITE: begin
                    if (cnt == MAX_C) begin
                        state <= ST_ERR;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        state <= last_q ? ST_DONE : ST_START;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_claim_loader.sv
// Directed bench for claim_loader: default instance plus a MAX_CLAIMS=2 instance.
module tb_claim_loader;

    localparam int AW = 11;
    localparam int FW = 10;
    localparam int DW = 4 * FW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic sel = 1'b0;

    logic          rdy_a, wen_a, dn_a, er_a, rdy_b, wen_b, dn_b, er_b;
    logic [AW-1:0] waddr_a, cc_a, waddr_b, cc_b;
    logic [DW-1:0] wdata_a, wdata_b;
    logic [2:0]    dbg_a, dbg_b;

    logic          rdy, wen, dn, er;
    logic [AW-1:0] waddr, cc;
    logic [DW-1:0] wdata;
    logic [2:0]    dbg;

    int tests = 0;
    int fails = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] got_q[$];

    claim_loader dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(rdy_a), .wr_en(wen_a), .wr_addr(waddr_a), .wr_data(wdata_a),
        .claim_count(cc_a), .done(dn_a), .error(er_a), .dbg_state(dbg_a)
    );

    claim_loader #(.MAX_CLAIMS(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(rdy_b), .wr_en(wen_b), .wr_addr(waddr_b), .wr_data(wdata_b),
        .claim_count(cc_b), .done(dn_b), .error(er_b), .dbg_state(dbg_b)
    );

    assign rdy   = sel ? rdy_b : rdy_a;
    assign wen   = sel ? wen_b : wen_a;
    assign dn    = sel ? dn_b : dn_a;
    assign er    = sel ? er_b : er_a;
    assign waddr = sel ? waddr_b : waddr_a;
    assign cc    = sel ? cc_b : cc_a;
    assign wdata = sel ? wdata_b : wdata_a;
    assign dbg   = sel ? dbg_b : dbg_a;

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Write monitor
    always @(negedge clk) begin
        if (!rst && wen) got_q.push_back({waddr, wdata});
    end

    function automatic logic [AW+DW-1:0] rec(input int a, input int x, input int y,
                                              input int w, input int h);
        return {AW'(a), FW'(x), FW'(y), FW'(w), FW'(h)};
    endfunction

    // Drivers: called at a falling edge, return at the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b, input logic last);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        while (!rdy && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!rdy) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: byte %02h not accepted, in_ready=%0b", b, rdy);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input logic last_final, input int max_gap);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], last_final && (i == s.len() - 1));
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
        @(negedge clk);
    endtask

    // Tests
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (rdy !== 1'b0) begin fails++; $display("FAIL reset_ready got %0b want 0", rdy); end
        tests++; if ({wen, dn, er} !== 3'b000) begin fails++; $display("FAIL reset_flags got %03b want 000", {wen, dn, er}); end
        tests++; if ({waddr, cc, wdata} !== '0) begin fails++; $display("FAIL reset_data got %h want 0", {waddr, cc, wdata}); end
        rst = 1'b0;
        @(negedge clk);
        tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL reset_release_ready got %0b want 1", rdy); end
        tests++; if (dbg !== 3'd0) begin fails++; $display("FAIL reset_state got %0d want 0", dbg); end
    endtask

    task automatic test_basic();
        do_reset();
        send_str("#1 @ 1,3: 4x4\n#2 @ 3,1: 4x4\n#3 @ 5,5: 2x2\n", 1'b1, 0);
        repeat (3) @(negedge clk);
        exp_q.push_back(rec(0, 1, 3, 4, 4));
        exp_q.push_back(rec(1, 3, 1, 4, 4));
        exp_q.push_back(rec(2, 5, 5, 2, 2));
        tests++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL basic_nwrites got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL basic_write%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        tests++; if (cc !== 11'd3) begin fails++; $display("FAIL basic_count got %0d want 3", cc); end
        tests++; if ({dn, er, rdy} !== 3'b100) begin fails++; $display("FAIL basic_done got done,err,rdy=%03b want 100", {dn, er, rdy}); end
    endtask

    task automatic test_gaps_no_newline();
        do_reset();
        send_str("#1 @ 1,3: 4x4\n#2 @ 3,1: 4x4\n#3 @ 5,5: 2x2", 1'b1, 3);
        repeat (3) @(negedge clk);
        exp_q.push_back(rec(0, 1, 3, 4, 4));
        exp_q.push_back(rec(1, 3, 1, 4, 4));
        exp_q.push_back(rec(2, 5, 5, 2, 2));
        tests++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL gaps_nwrites got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL gaps_write%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        tests++; if ({dn, er} !== 2'b10) begin fails++; $display("FAIL gaps_done got done,err=%02b want 10", {dn, er}); end
    endtask

    task automatic test_whitespace();
        do_reset();
        send_str("\n \t#3 @ 4 ,5: 6x7", 1'b0, 0);
        send_byte(8'h0d, 1'b0);
        send_byte(8'h0a, 1'b0);
        tests++; if (wen !== 1'b1) begin fails++; $display("FAIL ws_latency wr_en got %0b want 1", wen); end
        tests++; if (wdata !== rec(0, 4, 5, 6, 7)) begin fails++; $display("FAIL ws_data got %h want %h", wdata, rec(0, 4, 5, 6, 7)); end
        send_str("#9 @ 1 2", 1'b0, 0);
        tests++; if ({er, dn, cc} !== {2'b10, 11'd1}) begin fails++; $display("FAIL ws_digit_after_space got err,done,count=%0b,%0b,%0d want 1,0,1", er, dn, cc); end
    endtask

    task automatic test_field_max();
        do_reset();
        send_str("#7 @ 1023,0: 1x1\n", 1'b0, 1);
        repeat (2) @(negedge clk);
        tests++; if (got_q.size() !== 1) begin fails++; $display("FAIL max_nwrites got %0d want 1", got_q.size()); end
        else begin
            tests++; if (got_q[0] !== rec(0, 1023, 0, 1, 1)) begin fails++; $display("FAIL max_write got %h want %h", got_q[0], rec(0, 1023, 0, 1, 1)); end
        end
        send_str("#8 @ 1024", 1'b0, 0);
        repeat (2) @(negedge clk);
        tests++; if ({er, dn, rdy} !== 3'b100) begin fails++; $display("FAIL max_overflow got err,done,rdy=%03b want 100", {er, dn, rdy}); end
        tests++; if (cc !== 11'd1 || got_q.size() !== 1) begin fails++; $display("FAIL max_no_write got count=%0d writes=%0d want 1,1", cc, got_q.size()); end
    endtask

    task automatic test_bad_sep();
        do_reset();
        send_str("#1 @ 1;", 1'b0, 0);
        tests++; if ({er, dn, rdy} !== 3'b100) begin fails++; $display("FAIL badsep_err got err,done,rdy=%03b want 100", {er, dn, rdy}); end
        tests++; if (cc !== 11'd0) begin fails++; $display("FAIL badsep_count got %0d want 0", cc); end
    endtask

    task automatic test_capacity();
        sel = 1'b1;
        do_reset();
        send_str("#1 @ 0,0: 1x1\n#2 @ 1,1: 2x2\n#3 @ 2,2: 3x3\n", 1'b0, 0);
        repeat (3) @(negedge clk);
        exp_q.push_back(rec(0, 0, 0, 1, 1));
        exp_q.push_back(rec(1, 1, 1, 2, 2));
        tests++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL cap_nwrites got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL cap_write%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        tests++; if ({er, dn, cc} !== {2'b10, 11'd2}) begin fails++; $display("FAIL cap_err got err,done,count=%0b,%0b,%0d want 1,0,2", er, dn, cc); end
        sel = 1'b0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        send_str("#4 @ 2,2: 3x3\n#5 @ 12,", 1'b0, 0);
        tests++; if (cc !== 11'd1) begin fails++; $display("FAIL midrst_pre_count got %0d want 1", cc); end
        rst = 1'b1;
        @(negedge clk);
        tests++; if ({rdy, wen, dn, er} !== 4'b0000) begin fails++; $display("FAIL midrst_flags got %04b want 0000", {rdy, wen, dn, er}); end
        tests++; if ({waddr, cc, wdata} !== '0) begin fails++; $display("FAIL midrst_data got %h want 0", {waddr, cc, wdata}); end
        rst = 1'b0;
        got_q.delete();
        @(negedge clk);
        send_str("#1 @ 0,0: 1x1\n", 1'b1, 0);
        repeat (2) @(negedge clk);
        tests++; if (got_q.size() !== 1) begin fails++; $display("FAIL midrst_nwrites got %0d want 1", got_q.size()); end
        else begin
            tests++; if (got_q[0] !== rec(0, 0, 0, 1, 1)) begin fails++; $display("FAIL midrst_write got %h want %h", got_q[0], rec(0, 0, 0, 1, 1)); end
        end
        tests++; if ({dn, er, cc} !== {2'b10, 11'd1}) begin fails++; $display("FAIL midrst_done got done,err,count=%0b,%0b,%0d want 1,0,1", dn, er, cc); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_gaps_no_newline();
        test_whitespace();
        test_field_max();
        test_bad_sep();
        test_capacity();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
